// File: rtl/remap_cache_filler_pkg.sv
// Shared sizing defaults and filler FSM encodings for the remap cache write side.
package remap_cache_filler_pkg;

    localparam int LOCAL_ADDR_BW0 = 6;
    localparam int DATA_BW        = 8;
    localparam int VSIZE          = 4;
    localparam int N_ICFG         = 3;

    localparam int CV_BW   = $clog2(VSIZE);
    localparam int HBW     = LOCAL_ADDR_BW0 - CV_BW;
    localparam int OCC_BW  = HBW + 1;
    localparam int ICFG_BW = $clog2(N_ICFG + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/remap_region_ctr.sv
// Per-config ring region tracker: write pointer with wrap at size-1 and line occupancy.
module remap_region_ctr #(
    parameter int HBW    = remap_cache_filler_pkg::HBW,
    parameter int OCC_BW = HBW + 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_inc,
    input  logic              i_dec,
    input  logic [OCC_BW-1:0] i_size,
    output logic [HBW-1:0]    o_wptr,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_uflow
);

    logic [HBW-1:0]    r_wptr;
    logic [OCC_BW-1:0] r_occ;
    logic              w_last;
    logic [HBW-1:0]    w_wptr_nxt;

    assign w_last     = ({1'b0, r_wptr} == (i_size - OCC_BW'(1)));
    assign w_wptr_nxt = w_last ? '0 : r_wptr + HBW'(1);

    assign o_wptr  = r_wptr;
    assign o_full  = (r_occ == i_size);
    assign o_empty = (r_occ == '0);
    // A free against an empty region is dropped; a same-cycle fill cancels the free.
    assign o_uflow = i_dec & ~i_inc & o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_wptr <= '0;
            r_occ  <= '0;
        end else begin
            if (i_inc)
                r_wptr <= w_wptr_nxt;
            case ({i_inc, i_dec})
                2'b10:   r_occ <= r_occ + OCC_BW'(1);
                2'b01:   if (!o_empty) r_occ <= r_occ - OCC_BW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: rtl/remap_cache_filler.sv
// DRAM fill beats -> remap cache write strobe, with per-config ring credit tracking.
module remap_cache_filler #(
    parameter int LBW    = remap_cache_filler_pkg::LOCAL_ADDR_BW0,
    parameter int DBW    = remap_cache_filler_pkg::DATA_BW,
    parameter int VSIZE  = remap_cache_filler_pkg::VSIZE,
    parameter int N_ICFG = remap_cache_filler_pkg::N_ICFG,
    localparam int CV_BW   = $clog2(VSIZE),
    localparam int HBW     = LBW - CV_BW,
    localparam int ICFG_BW = $clog2(N_ICFG + 1),
    localparam int OCC_BW  = HBW + 1
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_cfg_dval,
    input  logic [N_ICFG-1:0][HBW-1:0]       i_bofs,
    input  logic [N_ICFG-1:0][OCC_BW-1:0]    i_bsize,
    input  logic                             i_flush,
    input  logic                             dramd_rdy,
    output logic                             dramd_ack,
    input  logic [ICFG_BW-1:0]               i_did,
    input  logic [VSIZE-1:0][DBW-1:0]        i_ddata,
    output logic                             wad_dval,
    output logic [ICFG_BW-1:0]               o_wid,
    output logic [HBW-1:0]                   o_whiaddr,
    output logic [VSIZE-1:0][DBW-1:0]        o_wdata,
    input  logic                             free_dval,
    input  logic [ICFG_BW-1:0]               i_free_id,
    output logic                             o_done,
    output logic                             o_underflow
);

    import remap_cache_filler_pkg::ST_IDLE;
    import remap_cache_filler_pkg::ST_RUN;
    import remap_cache_filler_pkg::ST_DRAIN;

    logic [1:0]                     r_state;
    logic [N_ICFG-1:0][HBW-1:0]     r_bofs;
    logic [N_ICFG-1:0][OCC_BW-1:0]  r_bsize;
    logic                           r_wad;
    logic [ICFG_BW-1:0]             r_wid;
    logic [HBW-1:0]                 r_whiaddr;
    logic [VSIZE-1:0][DBW-1:0]      r_wdata;
    logic                           r_done;
    logic                           r_underflow;

    logic [N_ICFG-1:0][HBW-1:0]     w_wptr;
    logic [N_ICFG-1:0]              w_full;
    logic [N_ICFG-1:0]              w_empty;
    logic [N_ICFG-1:0]              w_uflow;
    logic [N_ICFG-1:0]              w_inc;
    logic [N_ICFG-1:0]              w_dec;
    logic                           w_clr;
    logic                           w_sel_full;
    logic [HBW-1:0]                 w_sel_base;
    logic [HBW-1:0]                 w_sel_wptr;

    assign w_clr = (r_state == ST_IDLE) & i_cfg_dval;

    // Out-of-range ids never match a region, so they look permanently full.
    always_comb begin
        w_sel_full = 1'b1;
        w_sel_base = '0;
        w_sel_wptr = '0;
        for (int k = 0; k < N_ICFG; k++) begin
            if (i_did == ICFG_BW'(k)) begin
                w_sel_full = w_full[k];
                w_sel_base = r_bofs[k];
                w_sel_wptr = w_wptr[k];
            end
        end
    end

    assign dramd_ack = (r_state == ST_RUN) & dramd_rdy & ~w_sel_full;

    for (genvar k = 0; k < N_ICFG; k++) begin : g_region
        assign w_inc[k] = dramd_ack & (i_did == ICFG_BW'(k));
        assign w_dec[k] = free_dval & (r_state != ST_IDLE) & (i_free_id == ICFG_BW'(k));

        remap_region_ctr #(
            .HBW    (HBW),
            .OCC_BW (OCC_BW)
        ) u_ctr (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_clr   (w_clr),
            .i_inc   (w_inc[k]),
            .i_dec   (w_dec[k]),
            .i_size  (r_bsize[k]),
            .o_wptr  (w_wptr[k]),
            .o_full  (w_full[k]),
            .o_empty (w_empty[k]),
            .o_uflow (w_uflow[k])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_bofs      <= '0;
            r_bsize     <= '0;
            r_wad       <= 1'b0;
            r_wid       <= '0;
            r_whiaddr   <= '0;
            r_wdata     <= '0;
            r_done      <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wad  <= dramd_ack;
            r_done <= 1'b0;
            if (dramd_ack) begin
                r_wid     <= i_did;
                r_whiaddr <= w_sel_base + w_sel_wptr;
                r_wdata   <= i_ddata;
            end
            if (|w_uflow)
                r_underflow <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (i_cfg_dval) begin
                        r_bofs  <= i_bofs;
                        r_bsize <= i_bsize;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (i_flush)
                        r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // Wait for the last accepted beat's write to leave before idling.
                    if ((&w_empty) && !r_wad) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wad_dval    = r_wad;
    assign o_wid       = r_wid;
    assign o_whiaddr   = r_whiaddr;
    assign o_wdata     = r_wdata;
    assign o_done      = r_done;
    assign o_underflow = r_underflow;

endmodule

// File: tb/tb_remap_cache_filler.sv
// Directed bench for remap_cache_filler: ring addressing, credit return, underflow, drain, reset.
module tb_remap_cache_filler;
    import remap_cache_filler_pkg::*;

    localparam int NI = remap_cache_filler_pkg::N_ICFG;
    localparam int HB = remap_cache_filler_pkg::HBW;
    localparam int OB = remap_cache_filler_pkg::OCC_BW;
    localparam int IB = remap_cache_filler_pkg::ICFG_BW;
    localparam int VS = remap_cache_filler_pkg::VSIZE;
    localparam int DB = remap_cache_filler_pkg::DATA_BW;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      cfg_dval;
    logic [NI-1:0][HB-1:0]     bofs;
    logic [NI-1:0][OB-1:0]     bsize;
    logic                      flush;
    logic                      rdy;
    logic                      ack;
    logic [IB-1:0]             did;
    logic [VS-1:0][DB-1:0]     ddata;
    logic                      wad;
    logic [IB-1:0]             wid;
    logic [HB-1:0]             whiaddr;
    logic [VS-1:0][DB-1:0]     wdata;
    logic                      fr;
    logic [IB-1:0]             fr_id;
    logic                      done;
    logic                      uflow;

    int n_chk = 0;
    int n_err = 0;
    int n_done;

    always #5 clk = ~clk;

    remap_cache_filler dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cfg_dval  (cfg_dval),
        .i_bofs      (bofs),
        .i_bsize     (bsize),
        .i_flush     (flush),
        .dramd_rdy   (rdy),
        .dramd_ack   (ack),
        .i_did       (did),
        .i_ddata     (ddata),
        .wad_dval    (wad),
        .o_wid       (wid),
        .o_whiaddr   (whiaddr),
        .o_wdata     (wdata),
        .free_dval   (fr),
        .i_free_id   (fr_id),
        .o_done      (done),
        .o_underflow (uflow)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic cfg();
        @(negedge clk);
        cfg_dval = 1'b1;
        @(posedge clk);
        #1;
        cfg_dval = 1'b0;
    endtask

    // One cycle: offer a beat (and optionally a free), check ack, then the registered write.
    task automatic beat(input int id, input logic [31:0] d, input logic exp_ack,
                        input int exp_addr, input logic f_en, input int f_id, input string tag);
        @(negedge clk);
        rdy   = 1'b1;
        did   = IB'(id);
        ddata = d;
        fr    = f_en;
        fr_id = IB'(f_id);
        #1;
        chk({tag, ".ack"}, ack, exp_ack);
        @(posedge clk);
        #1;
        rdy = 1'b0;
        fr  = 1'b0;
        chk({tag, ".wad"}, wad, exp_ack);
        if (exp_ack) begin
            chk({tag, ".addr"}, whiaddr, exp_addr);
            chk({tag, ".wid"}, wid, id);
            chk({tag, ".data"}, wdata, d);
        end
    endtask

    initial begin
        rst = 1'b1; cfg_dval = 1'b0; flush = 1'b0; rdy = 1'b0; did = '0;
        ddata = '0; fr = 1'b0; fr_id = '0;
        bofs[0] = HB'(8); bofs[1] = HB'(2); bofs[2] = HB'(0);
        bsize[0] = OB'(4); bsize[1] = OB'(3); bsize[2] = OB'(2);

        // Reset state
        tick(); tick();
        chk("rst.wad", wad, 0);
        chk("rst.wid", wid, 0);
        chk("rst.addr", whiaddr, 0);
        chk("rst.data", wdata, 0);
        chk("rst.done", done, 0);
        chk("rst.uflow", uflow, 0);
        rst = 1'b0;
        beat(0, 32'h11111111, 0, 0, 0, 0, "idle");

        // Ring id0: base 8, size 4
        cfg();
        for (int k = 0; k < 4; k++)
            beat(0, 32'hA0A1A2A0 + k, 1, 8 + k, 0, 0, "fill0");
        beat(0, 32'hDEADBEEF, 0, 0, 0, 0, "full0");
        chk("full0.hold", whiaddr, 11);

        // Free on full id0 does not unblock the same cycle
        beat(0, 32'h0BADF00D, 0, 0, 1, 0, "freefull0");
        beat(0, 32'hC0C0C0C0, 1, 8, 0, 0, "wrap0");
        beat(0, 32'hC1C1C1C1, 0, 0, 0, 0, "refull0");

        // id1 base 2 size 3; fill+free same cycle keeps occ at 1
        beat(1, 32'h10000000, 1, 2, 0, 0, "id1a");
        beat(1, 32'h10000001, 1, 3, 1, 1, "id1both");
        beat(1, 32'h10000002, 1, 4, 0, 0, "id1b");
        beat(1, 32'h10000003, 1, 2, 0, 0, "id1c");
        beat(1, 32'h10000004, 0, 0, 0, 0, "id1full");

        // Underflow on empty id2, sticky; occ stays 0
        @(negedge clk);
        fr = 1'b1; fr_id = IB'(2);
        @(posedge clk);
        #1;
        fr = 1'b0;
        chk("uflow.set", uflow, 1);
        tick(); tick(); tick();
        chk("uflow.sticky", uflow, 1);
        beat(2, 32'h20000000, 1, 0, 0, 0, "id2a");
        beat(2, 32'h20000001, 1, 1, 0, 0, "id2b");
        beat(2, 32'h20000002, 0, 0, 0, 0, "id2full");
        beat(3, 32'h30000000, 0, 0, 0, 0, "badid");
        chk("run.done", done, 0);

        // Flush with a beat in flight, drain via frees
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst2.uflow", uflow, 0);
        cfg();
        beat(0, 32'h40000000, 1, 8, 0, 0, "dr0");
        beat(0, 32'h40000001, 1, 9, 0, 0, "dr1");
        flush = 1'b1;
        beat(0, 32'h40000002, 1, 10, 0, 0, "dr2flush");
        flush = 1'b0;
        beat(0, 32'h40000003, 0, 0, 0, 0, "drain.noack");
        for (int k = 0; k < 3; k++) begin
            beat(0, 32'h0, 0, 0, 1, 0, "drain.free");
            chk("drain.done", done, 0);
        end
        n_done = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done) n_done++;
        end
        chk("drain.done_cnt", n_done, 1);
        beat(0, 32'h50000000, 0, 0, 0, 0, "postdrain.idle");

        // Reset the cycle after an ack drops the write
        cfg();
        beat(0, 32'h60000000, 1, 8, 0, 0, "prerst");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmid.wad", wad, 0);
        chk("rstmid.addr", whiaddr, 0);
        chk("rstmid.data", wdata, 0);
        chk("rstmid.wid", wid, 0);
        rst = 1'b0;
        beat(0, 32'h70000000, 0, 0, 0, 0, "rstmid.idle");
        cfg();
        beat(0, 32'h70000001, 1, 8, 0, 0, "rstmid.recfg");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/remap_cache_filler.md
Name: remap_cache_filler

Overview:
- Write-side producer for the banked remap cache: takes DRAM fill beats tagged by input-config id and issues the cache write strobe (`wad`) with id, high address and vector data.
- Each config owns a ring region of high addresses. The filler tracks occupancy per config and blocks fills when a region is full.
- Consumes the cache's `free` strobe as credit return. Sits between the DRAM read-response path and the remap cache write port.

Parameters:
- LBW, TauCfg::LOCAL_ADDR_BW0, local word address width.
- DBW, TauCfg::DATA_BW, data width per lane.
- VSIZE, TauCfg::VSIZE, lanes per beat.
- N_ICFG, TauCfg::N_ICFG, number of input configs.
- Derived: CV_BW=$clog2(VSIZE), HBW=LBW-CV_BW, ICFG_BW=$clog2(N_ICFG+1), OCC_BW=HBW+1.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_cfg_dval  in  1  load region table (accepted only in IDLE)
- i_bofs  in  [N_ICFG][HBW]  region base high address per id
- i_bsize  in  [N_ICFG][OCC_BW]  region size in lines per id (1..NDATA)
- i_flush  in  1  stop accepting, drain, return to IDLE
- dramd_rdy  in  1  fill beat valid
- dramd_ack  out  1  fill beat accepted
- i_did  in  ICFG_BW  fill beat config id
- i_ddata  in  [VSIZE][DBW]  fill beat data
- wad_dval  out  1  cache write strobe
- o_wid  out  ICFG_BW  write config id
- o_whiaddr  out  HBW  write high address
- o_wdata  out  [VSIZE][DBW]  write data
- free_dval  in  1  one line of i_free_id released by the reader
- i_free_id  in  ICFG_BW  released config id
- o_done  out  1  one-cycle pulse on DRAIN→IDLE
- o_underflow  out  1  sticky: free received with zero occupancy

Behaviour:
- Reset values: state=IDLE; all wptr, occ and size registers 0; dramd_ack=0; wad_dval=0; o_wid/o_whiaddr/o_wdata=0; o_done=0; o_underflow=0.
- IDLE:
  - On i_cfg_dval, latch bofs[] and bsize[], clear wptr[] and occ[], go RUN.
  - Fill beats are not accepted in IDLE.
- RUN:
  - dramd_ack = dramd_rdy & (occ[i_did] != size[i_did]). This is combinational, so rdy/ack completes in the same cycle.
  - On ack, at the next edge: wad_dval=1, o_wid=i_did, o_whiaddr=bofs[i_did]+wptr[i_did] (mod 2^HBW), o_wdata=i_ddata. Latency is 1 cycle.
  - Also on ack: wptr[i_did] advances and wraps to 0 when it equals size-1; occ[i_did] is incremented.
  - With no ack on an edge, wad_dval returns to 0. The output data registers hold their values.
  - An i_did >= N_ICFG is never acked: it is treated as full.
- Free strobe:
  - On free_dval, occ[i_free_id] is decremented.
  - If occ is already 0, it is left unchanged and o_underflow sets (cleared only by reset).
  - Free strobes are honoured in RUN and DRAIN and ignored in IDLE.
- Simultaneous fill ack and free on the same id: occ is unchanged and wptr still advances.
- Full region: ack stays low until a free on that id. A free and a fill for the same full id in the same cycle still deny the ack, because ack is computed from registered occ.
- RUN→DRAIN on i_flush. In DRAIN, dramd_ack=0, but a wad_dval from the last accepted beat still issues.
- DRAIN→IDLE once every occ is 0 and wad_dval=0. o_done pulses in the cycle IDLE is entered.
- i_cfg_dval outside IDLE is ignored.
- i_rst has priority over all events. A reset mid-fill drops any pending wad write, so wad_dval=0 on the next cycle.

Decomposition:
- TauCfg: add OCC_BW and a filler-state enum {IDLE, RUN, DRAIN}. Reuse the existing rdyack/dval port macros.
- Sub-module remap_region_ctr (one instance per id, generate loop): holds wptr and occ with inc/dec/clear inputs, and produces full/empty and next-pointer with wrap.

Test Plan:
- Config bofs[0]=8, bsize[0]=4; send 4 beats id0 -> o_whiaddr 8,9,10,11 one cycle after each ack; 5th beat held with ack=0.
- Full id0, assert free_dval id0 -> next-cycle ack; write goes to hiaddr 8 (wrap), occ back to 4.
- Fill ack and free on id1 in the same cycle -> occ[1] unchanged, wptr[1] +1, wad_dval=1 next cycle.
- Free on id2 with occ=0 -> o_underflow=1 and stays 1; occ[2] stays 0.
- Fill 3 beats id0, i_flush, then 3 frees -> dramd_ack=0 during DRAIN; o_done pulses exactly once after the 3rd free; state IDLE.
- Reset asserted the cycle after an ack -> wad_dval=0 next cycle; all outputs 0; new beat not acked until i_cfg_dval.
